// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory port arbiter: channel FSM encoding,
// default bus widths and the grant-index width helper.
package mem_port_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 1024;

  // Grant index width: enough bits to name every requester, never below one.
  function automatic int calc_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One channel of the memory port arbiter: IDLE/BUSY FSM plus a round-robin
// pointer. The grant is captured on the IDLE->BUSY step and held until the
// transaction is released, so later requests cannot preempt it.
module rr_arbiter
  import mem_port_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               start,
  input  logic               rel,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);

  localparam int IDX_W = ID_W + 1;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   grant_r;
  logic [ID_W-1:0]   pick_s;
  logic [IDX_W-1:0]  sum_s;
  logic [ID_W-1:0]   idx_s;

  // Round-robin search: walk downward so the lowest offset from ptr wins.
  always_comb begin
    pick_s = ptr_r;
    sum_s  = {IDX_W{1'b0}};
    idx_s  = {ID_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s  = {1'b0, ptr_r} + IDX_W'(i);
      idx_s  = (sum_s >= IDX_W'(NUM_REQ)) ? ID_W'(sum_s - IDX_W'(NUM_REQ)) : ID_W'(sum_s);
      pick_s = req[idx_s] ? idx_s : pick_s;
    end
  end

  // Channel state register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant capture on start and pointer advance past the winner on release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_r <= {ID_W{1'b0}};
      ptr_r   <= {ID_W{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        grant_r <= pick_s;
      end
      if ((state_r == ST_BUSY) && rel) begin
        ptr_r <= (grant_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_r + ID_W'(1);
      end
    end
  end

  // Next state: a done seen in IDLE is ignored, a request seen in BUSY waits.
  always_comb begin
    case (state_r)
      ST_IDLE: state_nxt_s = start ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_nxt_s = rel ? ST_IDLE : ST_BUSY;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs straight from registers; grant id keeps the last winner in IDLE.
  always_comb begin
    busy     = (state_r == ST_BUSY);
    grant_id = grant_r;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one wide write/read memory port between NUM_REQ requesters.
// Write and read channels each own an rr_arbiter; this level adds the
// address/data muxes toward the AXI master and the done demuxes back.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_buffer,
  output logic [NUM_REQ-1:0]        req_wr_done,
  input  logic [NUM_REQ-1:0]        req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
  output logic [NUM_REQ-1:0]        req_rd_done,
  output logic [DATA_W-1:0]         req_rd_buffer,
  output logic                      wr_en,
  input  logic                      wr_done,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_buffer,
  output logic                      rd_en,
  input  logic                      rd_done,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rd_buffer,
  output logic [ID_W-1:0]           wr_grant_id,
  output logic [ID_W-1:0]           rd_grant_id,
  output logic                      wr_busy,
  output logic                      rd_busy
);

  logic              wr_start_s;
  logic              wr_rel_s;
  logic              rd_start_s;
  logic              rd_rel_s;
  logic [ADDR_W-1:0] wr_addr_arr_s [NUM_REQ];
  logic [DATA_W-1:0] wr_data_arr_s [NUM_REQ];
  logic [ADDR_W-1:0] rd_addr_arr_s [NUM_REQ];

  // Channel handshakes: start only from IDLE, release only from BUSY.
  always_comb begin
    wr_start_s = !wr_busy && (|req_wr_en);
    wr_rel_s   = wr_busy && wr_done;
    rd_start_s = !rd_busy && (|req_rd_en);
    rd_rel_s   = rd_busy && rd_done;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_wr_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req_wr_en),
    .start    (wr_start_s),
    .rel      (wr_rel_s),
    .grant_id (wr_grant_id),
    .busy     (wr_busy)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rd_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req_rd_en),
    .start    (rd_start_s),
    .rel      (rd_rel_s),
    .grant_id (rd_grant_id),
    .busy     (rd_busy)
  );

  // Unpack flattened requester buses so the muxes index by grant id.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_addr_arr_s[i] = req_wr_addr[i*ADDR_W +: ADDR_W];
      wr_data_arr_s[i] = req_wr_buffer[i*DATA_W +: DATA_W];
      rd_addr_arr_s[i] = req_rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Write channel: drive the granted request downstream, route done back.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = {ADDR_W{1'b0}};
    wr_buffer   = {DATA_W{1'b0}};
    req_wr_done = {NUM_REQ{1'b0}};
    if (wr_busy) begin
      wr_en                    = 1'b1;
      wr_addr                  = wr_addr_arr_s[wr_grant_id];
      wr_buffer                = wr_data_arr_s[wr_grant_id];
      req_wr_done[wr_grant_id] = wr_done;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Read channel: same as write, plus read data shown only in the done cycle.
  always_comb begin
    rd_en         = 1'b0;
    rd_addr       = {ADDR_W{1'b0}};
    req_rd_done   = {NUM_REQ{1'b0}};
    req_rd_buffer = {DATA_W{1'b0}};
    if (rd_busy) begin
      rd_en                    = 1'b1;
      rd_addr                  = rd_addr_arr_s[rd_grant_id];
      req_rd_done[rd_grant_id] = rd_done;
      req_rd_buffer            = rd_done ? rd_buffer : {DATA_W{1'b0}};
    end else begin
      rd_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (NUM_REQ=2): the stimulus process
// queues the expected owner/address/data of every completion, and a monitor
// pops and compares whenever a requester done pulse appears.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 1024;

  typedef struct {
    logic [NR-1:0] done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic [NR-1:0]   req_wr_en;
  logic [NR*AW-1:0] req_wr_addr;
  logic [NR*DW-1:0] req_wr_buffer;
  logic [NR-1:0]   req_wr_done;
  logic [NR-1:0]   req_rd_en;
  logic [NR*AW-1:0] req_rd_addr;
  logic [NR-1:0]   req_rd_done;
  logic [DW-1:0]   req_rd_buffer;
  logic            wr_en;
  logic            wr_done;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_buffer;
  logic            rd_en;
  logic            rd_done;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_buffer;
  logic [0:0]      wr_grant_id;
  logic [0:0]      rd_grant_id;
  logic            wr_busy;
  logic            rd_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t wr_q[$];
  exp_t rd_q[$];

  bit   auto_wr, auto_rd;
  int   wr_lat, rd_lat, wcnt, rcnt;

  localparam logic [DW-1:0] B0  = {16{64'h0123_4567_89AB_CDEF}};
  localparam logic [DW-1:0] B1  = {16{64'hFEDC_BA98_7654_3210}};
  localparam logic [DW-1:0] A5  = {128{8'hA5}};
  localparam logic [AW-1:0] WA0 = 32'h1000_0000;
  localparam logic [AW-1:0] WA1 = 32'h2000_0000;
  localparam logic [AW-1:0] RA0 = 32'h4000_0000;
  localparam logic [AW-1:0] RA1 = 32'h3000_0000;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_wr_en     (req_wr_en),
    .req_wr_addr   (req_wr_addr),
    .req_wr_buffer (req_wr_buffer),
    .req_wr_done   (req_wr_done),
    .req_rd_en     (req_rd_en),
    .req_rd_addr   (req_rd_addr),
    .req_rd_done   (req_rd_done),
    .req_rd_buffer (req_rd_buffer),
    .wr_en         (wr_en),
    .wr_done       (wr_done),
    .wr_addr       (wr_addr),
    .wr_buffer     (wr_buffer),
    .rd_en         (rd_en),
    .rd_done       (rd_done),
    .rd_addr       (rd_addr),
    .rd_buffer     (rd_buffer),
    .wr_grant_id   (wr_grant_id),
    .rd_grant_id   (rd_grant_id),
    .wr_busy       (wr_busy),
    .rd_busy       (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act[255:0], exp[255:0]);
    end
  endtask

  function automatic exp_t mk(input logic [NR-1:0] d, input logic [AW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.done = d;
    e.addr = a;
    e.data = b;
    return e;
  endfunction

  // Advance one clock and play the downstream AXI side (done after N cycles of en).
  task automatic step();
    @(posedge clk);
    #1;
    if (wr_done) begin
      wr_done = 1'b0;
    end else if (auto_wr && wr_en) begin
      wcnt++;
      if (wcnt == wr_lat) begin
        wr_done = 1'b1;
        wcnt    = 0;
      end
    end
    if (rd_done) begin
      rd_done = 1'b0;
    end else if (auto_rd && rd_en) begin
      rcnt++;
      if (rcnt == rd_lat) begin
        rd_done = 1'b1;
        rcnt    = 0;
      end
    end
  endtask

  task automatic wait_wr_done();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (wr_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wr_done_timeout", ok, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rstn = 1'b0;
    @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  // Monitor: compare every requester-side completion against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (req_wr_done != '0) begin
      if (wr_q.size() == 0) begin
        chk("wr_done_unexpected", req_wr_done, '0);
      end else begin
        e = wr_q.pop_front();
        chk("wr_done_owner", req_wr_done, e.done);
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_buffer", wr_buffer, e.data);
      end
    end
    if (req_rd_done != '0) begin
      if (rd_q.size() == 0) begin
        chk("rd_done_unexpected", req_rd_done, '0);
      end else begin
        e = rd_q.pop_front();
        chk("rd_done_owner", req_rd_done, e.done);
        chk("rd_addr", rd_addr, e.addr);
        chk("req_rd_buffer", req_rd_buffer, e.data);
      end
    end else begin
      chk("req_rd_buffer_idle", req_rd_buffer, '0);
    end
  end

  initial begin
    int seq [6] = '{0, 1, 0, 0, 0, 0};
    rstn = 1'b0;
    req_wr_en = '0; req_rd_en = '0;
    req_wr_addr = {WA1, WA0};
    req_wr_buffer = {B1, B0};
    req_rd_addr = {RA1, RA0};
    wr_done = 1'b0; rd_done = 1'b0;
    rd_buffer = A5;
    auto_wr = 1'b0; auto_rd = 1'b0;
    wr_lat = 2; rd_lat = 2; wcnt = 0; rcnt = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_wr_busy", wr_busy, 1'b0);
    chk("rst_wr_grant", wr_grant_id, 1'b0);
    chk("rst_rd_grant", rd_grant_id, 1'b0);
    @(posedge clk);
    #3 rstn = 1'b1;

    // Single write, done after 5 cycles of wr_en
    auto_wr = 1'b1; wr_lat = 5; wcnt = 0;
    req_wr_en = 2'b01;
    wr_q.push_back(mk(2'b01, WA0, B0));
    @(negedge clk);
    chk("single_en_not_yet", wr_en, 1'b0);
    step();
    @(negedge clk);
    chk("single_en_rise", wr_en, 1'b1);
    chk("single_addr", wr_addr, WA0);
    chk("single_data", wr_buffer, B0);
    wait_wr_done();
    req_wr_en = 2'b00;
    step();
    @(negedge clk);
    chk("single_idle_en", wr_en, 1'b0);
    chk("single_grant_hold", wr_grant_id, 1'b0);
    step();

    // Contention from reset: grant 0, exactly one IDLE cycle, grant 1
    do_reset();
    wr_lat = 2; wcnt = 0;
    req_wr_en = 2'b11;
    wr_q.push_back(mk(2'b01, WA0, B0));
    wr_q.push_back(mk(2'b10, WA1, B1));
    wait_wr_done();
    req_wr_en[0] = 1'b0;
    step();
    @(negedge clk);
    chk("cont_idle_gap", wr_busy, 1'b0);
    step();
    @(negedge clk);
    chk("cont_busy2", wr_busy, 1'b1);
    chk("cont_grant2", wr_grant_id, 1'b1);
    wait_wr_done();
    req_wr_en[1] = 1'b0;
    step();

    // Fairness: requester 0 persistent, requester 1 once
    req_wr_en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wr_q.push_back(seq[k] == 1 ? mk(2'b10, WA1, B1) : mk(2'b01, WA0, B0));
    end
    for (int k = 0; k < 6; k++) begin
      wait_wr_done();
      chk("fair_grant", wr_grant_id, seq[k]);
      if (seq[k] == 1) req_wr_en[1] = 1'b0;
      if (k == 5) req_wr_en[0] = 1'b0;
    end
    step();

    // Concurrent channels: requester 0 writes, requester 1 reads
    wr_lat = 4; rd_lat = 3; wcnt = 0; rcnt = 0; auto_rd = 1'b1;
    req_wr_en = 2'b01;
    req_rd_en = 2'b10;
    wr_q.push_back(mk(2'b01, WA0, B0));
    rd_q.push_back(mk(2'b10, RA1, A5));
    step();
    @(negedge clk);
    chk("conc_wr_busy", wr_busy, 1'b1);
    chk("conc_rd_busy", rd_busy, 1'b1);
    chk("conc_rd_addr", rd_addr, RA1);
    for (int i = 0; i < 30 && (req_wr_en != '0 || req_rd_en != '0); i++) begin
      step();
      if (wr_done) req_wr_en = 2'b00;
      if (rd_done) req_rd_en = 2'b00;
    end
    chk("conc_complete", {req_wr_en, req_rd_en}, '0);
    step();
    step();

    // Reset mid-transaction: requester 1 granted (write ptr is 1), no done
    auto_wr = 1'b0; auto_rd = 1'b0;
    req_wr_en = 2'b10;
    step();
    @(negedge clk);
    chk("midrst_busy", wr_busy, 1'b1);
    chk("midrst_grant", wr_grant_id, 1'b1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_wr_busy", wr_busy, 1'b0);
    chk("midrst_wr_grant", wr_grant_id, 1'b0);
    chk("midrst_wr_addr", wr_addr, '0);
    req_wr_en = 2'b00;
    @(posedge clk);
    #3 rstn = 1'b1;
    auto_wr = 1'b1; wr_lat = 2; wcnt = 0;
    req_wr_en = 2'b11;
    wr_q.push_back(mk(2'b01, WA0, B0));
    wait_wr_done();
    chk("midrst_regrant_ptr0", wr_grant_id, 1'b0);
    req_wr_en = 2'b00;
    step();
    step();

    // Stray done pulses while both channels are IDLE
    auto_wr = 1'b0; auto_rd = 1'b0;
    wr_done = 1'b1; rd_done = 1'b1;
    @(negedge clk);
    chk("stray_req_wr_done", req_wr_done, '0);
    chk("stray_req_rd_done", req_rd_done, '0);
    step();
    @(negedge clk);
    chk("stray_wr_idle", wr_busy, 1'b0);
    chk("stray_rd_idle", rd_busy, 1'b0);
    // Pointers must be untouched: write ptr 1, read ptr 0
    auto_wr = 1'b1; auto_rd = 1'b1; wcnt = 0; rcnt = 0; wr_lat = 2; rd_lat = 2;
    req_wr_en = 2'b11;
    req_rd_en = 2'b11;
    wr_q.push_back(mk(2'b10, WA1, B1));
    rd_q.push_back(mk(2'b01, RA0, A5));
    for (int i = 0; i < 30 && (req_wr_en != '0 || req_rd_en != '0); i++) begin
      step();
      if (wr_done) req_wr_en = 2'b00;
      if (rd_done) req_rd_en = 2'b00;
    end
    chk("stray_complete", {req_wr_en, req_rd_en}, '0);
    repeat (3) step();

    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 1024-bit write/read memory port between NUM_REQ requester IPs. The port is the en/done/addr/buffer interface driven into the AXI master.
- Write and read channels are arbitrated independently. Each channel uses a round-robin arbiter with grant locked for a whole transaction.
- Sits between several test/compute IPs and the single AXI master port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 1024, burst buffer width.
- ID_W (localparam), max(1, clog2(NUM_REQ)), grant index width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_wr_en  in  NUM_REQ  per-requester write request, held until its req_wr_done
- req_wr_addr  in  NUM_REQ*ADDR_W  flattened write addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
- req_wr_buffer  in  NUM_REQ*DATA_W  flattened write data
- req_wr_done  out  NUM_REQ  one-cycle done pulse to the granted writer
- req_rd_en  in  NUM_REQ  per-requester read request, held until its req_rd_done
- req_rd_addr  in  NUM_REQ*ADDR_W  flattened read addresses
- req_rd_done  out  NUM_REQ  one-cycle done pulse to the granted reader
- req_rd_buffer  out  DATA_W  read data, broadcast to all requesters, valid in the req_rd_done cycle
- wr_en  out  1  downstream write request
- wr_done  in  1  downstream write completion pulse
- wr_addr  out  ADDR_W  downstream write address
- wr_buffer  out  DATA_W  downstream write data
- rd_en  out  1  downstream read request
- rd_done  in  1  downstream read completion pulse
- rd_addr  out  ADDR_W  downstream read address
- rd_buffer  in  DATA_W  downstream read data
- wr_grant_id  out  ID_W  current or last write grant
- rd_grant_id  out  ID_W  current or last read grant
- wr_busy  out  1  write channel in BUSY
- rd_busy  out  1  read channel in BUSY

Behaviour:
- Reset, asynchronous with rstn=0:
  - Both channel FSMs go to IDLE.
  - Round-robin pointers are 0; grant ids are 0.
  - All outputs are 0, including req_rd_buffer.
  - An in-flight transaction is abandoned; no done is forwarded.
- Per channel, FSM states are IDLE and BUSY. The write and read channels are identical and fully independent; the read description substitutes rd_* for wr_*.
- IDLE:
  - If any req_wr_en bit is set, register grant = first set bit searching from ptr upward, wrapping modulo NUM_REQ, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY outputs:
  - wr_en = 1.
  - wr_addr and wr_buffer are combinationally muxed from the granted requester's slices.
  - Outside BUSY, wr_en, wr_addr and wr_buffer are 0.
- Completion in BUSY:
  - wr_done=1 gives req_wr_done[grant]=1 in the same cycle (combinational pass-through).
  - ptr <= (grant+1) mod NUM_REQ, and the FSM returns to IDLE.
- Read completion in BUSY:
  - rd_done=1 gives req_rd_done[grant]=1.
  - req_rd_buffer = rd_buffer in that cycle; otherwise req_rd_buffer = 0.
- Latency:
  - Requester en to downstream en: 1 cycle.
  - Downstream done to requester done: 0 cycles.
  - Minimum spacing between transactions on one channel: 1 IDLE cycle. That cycle also absorbs the requester's en, which is still high in its done cycle, so no spurious regrant occurs.
- Simultaneous requests are resolved by round robin from ptr.
  - NUM_REQ=2, ptr=0, both requesting: grant 0, then grant 1, then grant 0.
- A single persistent requester is re-granted after every IDLE cycle.
- A done pulse seen in IDLE is ignored; no req_*_done is produced.
- Grant is locked for the whole transaction.
  - If the granted requester drops en while BUSY (protocol violation), wr_en stays 1 until wr_done; no abort.
  - New requests never preempt the granted one.
- Write and read may be BUSY concurrently, including to the same address. Ordering between channels is not guaranteed; requesters sequence their own write-then-read.
- wr_grant_id/rd_grant_id hold the last grant after returning to IDLE.

Decomposition:
- Package mem_port_pkg holds:
  - the FSM state encoding (IDLE=0, BUSY=1);
  - the ADDR_W/DATA_W defaults;
  - a clog2-based ID_W helper.
- Sub-module rr_arbiter (NUM_REQ, ID_W):
  - Ports: clk, rstn, req, start (IDLE and any req), release (done in BUSY), grant_id, busy.
  - It contains the FSM and the pointer.
- The arbiter instantiates rr_arbiter twice, once per channel, plus the addr/data muxes and done demuxes.

Test Plan:
- Single write: req_wr_en[0]=1, addr 0x1000_0000, data pattern; wr_done after 5 cycles.
  - Required: wr_en rises 1 cycle after request, with wr_addr=0x1000_0000 and wr_buffer equal to the pattern.
  - Required: req_wr_done[0] pulses exactly once, in the wr_done cycle.
- Contention: NUM_REQ=2, both req_wr_en set simultaneously from reset, addresses 0x1000_0000 and 0x2000_0000.
  - Required grant order: 0 then 1, separated by exactly 1 IDLE cycle.
  - Required: each req_wr_done goes only to its owner.
- Fairness: requester 0 requests continuously and requester 1 requests once, on 6 completions.
  - Required grant sequence: 0,1,0,0,... Requester 1 waits at most one transaction.
- Concurrent channels: requester 0 writes while requester 1 reads; rd_buffer=0xA5...A5.
  - Required: wr_busy and rd_busy are both 1 simultaneously.
  - Required: req_rd_buffer=0xA5...A5 only in the req_rd_done[1] cycle, and 0 otherwise.
- Reset mid-transaction: assert rstn=0 while BUSY, before wr_done.
  - Required: wr_en, wr_busy and wr_grant_id go to 0 immediately, asynchronously.
  - Required: after release, a new request is granted from ptr=0.
- Stray done: pulse wr_done and rd_done while IDLE.
  - Required: no req_*_done, the FSM stays IDLE, and ptr is unchanged.
